pe_result_collector: RTL
========================

Name: pe_result_collector

Overview:
- Sits directly downstream of the PE array in the oBTC miner datapath.
- Captures the 14-bit dot-product sums from a bank of NPE PEs, group by group, until all ROWS matrix rows are done.
- Reduces each sum to a nibble (sum[13:10]) and XORs it with the matching nibble of the latched SHA3 hash.
- Presents the assembled ROWS*4-bit result to the final hashing stage over a valid/ready handshake, and pulses clear back to the PE array after each captured group.

Parameters:
- ROWS, 64, matrix rows (one nibble of result per row).
- NPE, 16, PEs delivering results in parallel per group; ROWS % NPE == 0 is required.
- PE_W, 14, width of each PE sum.
- SHIFT, 10, right shift applied to each sum; result nibble = sum[SHIFT+3:SHIFT].

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start_i  in  1  begin a new job; sampled only in IDLE.
- hash_i  in  ROWS*4  SHA3 hash; latched when start_i is accepted.
- pe_sum_i  in  NPE*PE_W  PE outputs; PE k occupies bits [k*PE_W +: PE_W].
- pe_valid_i  in  1  pe_sum_i holds a complete group.
- pe_ready_o  out  1  collector accepts a group this cycle.
- pe_clr_o  out  1  one-cycle clear pulse to the PE array.
- busy_o  out  1  state != IDLE.
- res_o  out  ROWS*4  XOR result; nibble r at [4r +: 4].
- res_valid_o  out  1  res_o is valid.
- res_ready_i  in  1  downstream accepts res_o.

Behaviour:
- Derived constants: NGROUP = ROWS/NPE; grp_cnt width = max(1, $clog2(NGROUP)).
- Reset: all outputs 0 (pe_ready_o, pe_clr_o, busy_o, res_valid_o, res_o); state=IDLE; grp_cnt=0; latched hash=0.
- State IDLE:
  - start_i=1: latch hash_i, clear res_o to 0, grp_cnt=0, go to COLLECT next cycle.
  - pe_valid_i is ignored in IDLE.
- State COLLECT:
  - pe_ready_o=1 combinationally from state.
  - Accept on pe_valid_i & pe_ready_o. For each k in 0..NPE-1 with row r = grp_cnt*NPE + k: res_o[4r+:4] <= hash_q[4r+:4] ^ pe_sum_i[k*PE_W+SHIFT +: 4].
  - On accept: grp_cnt++ and pe_clr_o=1 on the following cycle (registered, exactly one cycle wide).
  - Accept of the last group (grp_cnt==NGROUP-1): go to OUTPUT; res_valid_o=1 on the next cycle; grp_cnt wraps to 0.
  - Latency: last accepted group to res_valid_o is 1 cycle.
- State OUTPUT:
  - res_valid_o=1 and res_o held stable until res_ready_i=1.
  - On handshake: res_valid_o=0 next cycle, go to IDLE.
  - pe_ready_o=0, so upstream is backpressured.
- start_i while busy (COLLECT or OUTPUT): ignored; no relatch and no restart.
- res_ready_i with res_valid_o=0: no effect.
- Same-cycle start_i and res_ready_i in OUTPUT: only the handshake takes effect; start_i must be reissued in IDLE (earliest the following cycle).
- Back-to-back jobs: minimum gap between res handshake and next start acceptance is 1 cycle (IDLE).
- pe_valid_i held high across consecutive cycles in COLLECT: one group accepted per cycle.
- Sum bits above SHIFT+3 are discarded; bits below SHIFT are discarded. No saturation.
- rst asserted mid-job: next cycle returns to the reset values above. A partial result is never emitted. No pe_clr_o pulse is generated by reset itself.

Decomposition:
- Package obtc_pkg:
  - localparams ROWS_DEF=64, PE_W_DEF=14, SHIFT_DEF=10.
  - typedef enum logic [1:0] {IDLE, COLLECT, OUTPUT} collect_state_t.
  - typedef logic [255:0] hash_t.
- One natural sub-module: pe_nibble_xor (combinational, NPE lanes).
  - In: NPE sums plus NPE hash nibbles.
  - Out: NPE XORed nibbles.
  - The top instantiates it once, feeding the hash slice selected by grp_cnt; the FSM, counter and result register stay in the top.

Test Plan:
- Reset then idle: rst high 2 cycles -> all outputs 0. pe_valid_i=1 in IDLE -> pe_ready_o stays 0 and res_o unchanged.
- Single job, hash=0, every sum=14'h0400 over 4 back-to-back groups -> res_valid_o 1 cycle after group 3, res_o = {64{4'h1}}; pe_clr_o pulses 4 times, one cycle after each accept.
- XOR/shift check: hash nibble r = r[3:0], sum for row r = (r[3:0]<<10) | 10'h3FF -> every result nibble 0. Max sum 14'h3840 with hash 0 -> nibble 4'hE.
- Backpressure: res_ready_i=0 for 10 cycles -> res_o stable, pe_ready_o=0, extra start_i ignored. res_ready_i=1 -> IDLE next cycle, busy_o=0.
- Gapped input: pe_valid_i toggled 1,0,0,1,... -> only valid cycles advance grp_cnt; result identical to the back-to-back case.
- Reset mid-job after group 2 -> state IDLE, res_valid_o never asserts. A fresh job then completes with the correct result, with no residue from the aborted job.

Source files
------------

// File: rtl/obtc_pkg.sv
// ============================================================================
// obtc_pkg : shared types and defaults for the oBTC miner datapath
// Rev 1.0
// ============================================================================
`default_nettype none

package obtc_pkg;

  localparam int ROWS_DEF  = 64;
  localparam int PE_W_DEF  = 14;
  localparam int SHIFT_DEF = 10;

  typedef enum logic [1:0] {IDLE, COLLECT, OUTPUT} collect_state_t;

  typedef logic [255:0] hash_t;

  // Group counter width, never narrower than one bit.
  function automatic int grp_width(input int ngroup);
    return (ngroup > 1) ? $clog2(ngroup) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pe_nibble_xor.sv
// ============================================================================
// pe_nibble_xor : reduces NPE PE sums to nibbles and XORs them with hash nibbles
// Rev 1.0
// ============================================================================
`default_nettype none

module pe_nibble_xor #(
  parameter int NPE   = 16,
  parameter int PE_W  = 14,
  parameter int SHIFT = 10
) (
  input  logic [NPE*PE_W-1:0] sum_i,
  input  logic [NPE*4-1:0]    hash_nib_i,
  output logic [NPE*4-1:0]    nib_o
);

  logic [NPE-1:0] w_unused_bits;

  for (genvar k = 0; k < NPE; k++) begin : g_lane
    logic [PE_W-1:0] w_sum;
    assign w_sum = sum_i[k*PE_W +: PE_W];
    assign nib_o[k*4 +: 4] = hash_nib_i[k*4 +: 4] ^ w_sum[SHIFT +: 4];
    // Bits outside the selected nibble are intentionally dropped.
    assign w_unused_bits[k] = ^w_sum;
  end

endmodule

`default_nettype wire

// File: rtl/pe_result_collector.sv
// ============================================================================
// pe_result_collector : gathers PE group sums, XORs with latched hash, and
// hands the assembled result downstream over valid/ready
// Rev 1.0
// ============================================================================
`default_nettype none

module pe_result_collector
  import obtc_pkg::*;
#(
  parameter int ROWS  = ROWS_DEF,
  parameter int NPE   = 16,
  parameter int PE_W  = PE_W_DEF,
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [ROWS*4-1:0]   hash_i,
  input  logic [NPE*PE_W-1:0] pe_sum_i,
  input  logic                pe_valid_i,
  output logic                pe_ready_o,
  output logic                pe_clr_o,
  output logic                busy_o,
  output logic [ROWS*4-1:0]   res_o,
  output logic                res_valid_o,
  input  logic                res_ready_i
);

  localparam int NGROUP = ROWS / NPE;
  localparam int GW     = grp_width(NGROUP);
  localparam int BW     = $clog2(ROWS * 4);

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_COLLECT = COLLECT;
  localparam logic [1:0] S_OUTPUT  = OUTPUT;

  localparam logic [GW-1:0] c_last_grp = GW'(NGROUP - 1);

  logic [1:0]        r_state;
  logic [GW-1:0]     r_grp;
  logic [ROWS*4-1:0] r_hash;
  logic [ROWS*4-1:0] r_res;
  logic              r_clr;

  logic              w_accept;
  logic [BW-1:0]     w_base;
  logic [NPE*4-1:0]  w_xor;

  assign pe_ready_o  = (r_state == S_COLLECT);
  assign busy_o      = (r_state != S_IDLE);
  assign res_valid_o = (r_state == S_OUTPUT);
  assign pe_clr_o    = r_clr;
  assign res_o       = r_res;

  assign w_accept = pe_valid_i & pe_ready_o;
  // Bit offset of the current group's nibbles within hash and result.
  assign w_base   = BW'(r_grp) * BW'(NPE * 4);

  pe_nibble_xor #(
    .NPE   (NPE),
    .PE_W  (PE_W),
    .SHIFT (SHIFT)
  ) u_nibble_xor (
    .sum_i      (pe_sum_i),
    .hash_nib_i (r_hash[w_base +: NPE*4]),
    .nib_o      (w_xor)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_grp   <= '0;
      r_hash  <= '0;
      r_res   <= '0;
      r_clr   <= 1'b0;
    end else begin
      r_clr <= w_accept;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_hash  <= hash_i;
            r_res   <= '0;
            r_grp   <= '0;
            r_state <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (w_accept) begin
            r_res[w_base +: NPE*4] <= w_xor;
            if (r_grp == c_last_grp) begin
              r_grp   <= '0;
              r_state <= S_OUTPUT;
            end else begin
              r_grp <= r_grp + 1'b1;
            end
          end
        end
        S_OUTPUT: begin
          if (res_ready_i) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
